// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the round-robin BRAM arbiter.
// Holds the arbiter state enum, pointer width and the wrap-around increment.
package bram_arb_pkg;

  localparam int unsigned MAX_NUM_REQ = 4;
  localparam int unsigned PTR_W       = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Advance a requester pointer by one, wrapping at n requesters.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int unsigned n);
    logic [PTR_W-1:0] r;
    if (32'(p) + 32'd1 >= n) begin
      r = '0;
    end else begin
      r = p + PTR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester and BRAM-side bus of the arbiter.
// slave: the arbiter itself; master: the environment (clients plus BRAM).
interface bram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wen;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            gnt;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            rvalid;
  logic                          bram_ce;
  logic                          bram_wen;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_din;
  logic [DATA_WIDTH-1:0]         bram_dout;

  modport slave (
    input  req, req_wen, req_addr, req_din, req_lock, bram_dout,
    output gnt, rdata, rvalid, bram_ce, bram_wen, bram_addr, bram_din
  );

  modport master (
    output req, req_wen, req_addr, req_din, req_lock, bram_dout,
    input  gnt, rdata, rvalid, bram_ce, bram_wen, bram_addr, bram_din
  );

endinterface

// File: rtl/bram_arbiter_rr_picker.sv
// Combinational find-first-set over req, starting at ptr and wrapping.
// Outputs the one-hot winner, its index and a valid flag.
module rr_picker
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   idx,
  output logic               valid
);

  logic [MAX_NUM_REQ-1:0] req_ext_s;
  logic [PTR_W:0]         cand_sum_s;
  logic [PTR_W-1:0]       cand_s;

  // Zero-padding lets the candidate index address the vector at full width.
  assign req_ext_s = MAX_NUM_REQ'(req);

  // Scan the rotated request vector; the first set bit wins.
  always_comb begin
    onehot     = '0;
    idx        = '0;
    valid      = 1'b0;
    cand_sum_s = '0;
    cand_s     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s = {1'b0, ptr} + (PTR_W+1)'(k);
      cand_sum_s = (cand_sum_s >= (PTR_W+1)'(NUM_REQ)) ? (cand_sum_s - (PTR_W+1)'(NUM_REQ)) : cand_sum_s;
      cand_s     = cand_sum_s[PTR_W-1:0];
      if (!valid && req_ext_s[cand_s]) begin
        valid  = 1'b1;
        idx    = cand_s;
        onehot = NUM_REQ'(1) << cand_s;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between NUM_REQ clients.
// Optional burst locking is compiled in with the BRAM_ARB_BURST_EN macro.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic          ck,
  input  logic          rst,
  bram_arbiter_if.slave bus
);

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       rr_idx_s, win_idx_s, mux_idx_s;
  logic [NUM_REQ-1:0]     rr_onehot_s, gnt_s;
  logic                   rr_valid_s, win_valid_s, rd_grant_s;
  logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [MAX_NUM_REQ-1:0] wen_ext_s;
  logic [ADDR_WIDTH-1:0]  addr_arr_s [MAX_NUM_REQ];
  logic [DATA_WIDTH-1:0]  din_arr_s  [MAX_NUM_REQ];

  assign wen_ext_s = MAX_NUM_REQ'(bus.req_wen);

  // Unpack the flattened buses; unused slots are padded so a PTR_W index is always in range.
  for (genvar i = 0; i < MAX_NUM_REQ; i++) begin : g_slice
    if (i < NUM_REQ) begin : g_live
      assign addr_arr_s[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign din_arr_s[i]  = bus.req_din[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign addr_arr_s[i] = '0;
      assign din_arr_s[i]  = '0;
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (rr_onehot_s),
    .idx    (rr_idx_s),
    .valid  (rr_valid_s)
  );

`ifdef BRAM_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t             state_q, state_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAX_NUM_REQ-1:0] req_ext_s, lock_ext_s;

  assign req_ext_s  = MAX_NUM_REQ'(bus.req);
  assign lock_ext_s = MAX_NUM_REQ'(bus.req_lock);

  // Winner selection and pointer/lock bookkeeping; LOCKED bypasses round-robin.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = rr_idx_s;
    gnt_s       = '0;
    ptr_d       = ptr_q;
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          win_valid_s = rr_valid_s;
          gnt_s       = rr_onehot_s;
          ptr_d       = rr_valid_s ? ptr_inc(rr_idx_s, NUM_REQ) : ptr_q;
          if (rr_valid_s && lock_ext_s[rr_idx_s] && (MAX_BURST > 1)) begin
            state_d = LOCKED;
            owner_d = rr_idx_s;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        LOCKED: begin
          win_idx_s = owner_q;
          if (req_ext_s[owner_q]) begin
            win_valid_s = 1'b1;
            gnt_s       = NUM_REQ'(1) << owner_q;
            cnt_d       = cnt_q + CNT_W'(1);
            if (!lock_ext_s[owner_q] || (cnt_q + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
              state_d = IDLE;
              ptr_d   = ptr_inc(owner_q, NUM_REQ);
              cnt_d   = '0;
            end else begin
              state_d = LOCKED;
            end
          end else begin
            state_d = IDLE;
            ptr_d   = ptr_inc(owner_q, NUM_REQ);
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Burst FSM registers.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^{bus.req_lock, 32'(MAX_BURST)};

  // Plain round-robin winner selection and pointer advance.
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = rr_idx_s;
    gnt_s       = '0;
    ptr_d       = ptr_q;
    if (rst) begin
      win_valid_s = 1'b0;
    end else begin
      win_valid_s = rr_valid_s;
      gnt_s       = rr_onehot_s;
      ptr_d       = rr_valid_s ? ptr_inc(rr_idx_s, NUM_REQ) : ptr_q;
    end
  end
`endif

  // BRAM port mux; with no winner the slot-0 values are presented as don't-care.
  always_comb begin
    mux_idx_s     = win_valid_s ? win_idx_s : '0;
    rd_grant_s    = win_valid_s && !wen_ext_s[mux_idx_s];
    bus.gnt       = gnt_s;
    bus.bram_ce   = win_valid_s;
    bus.bram_wen  = win_valid_s && wen_ext_s[mux_idx_s];
    bus.bram_addr = addr_arr_s[mux_idx_s];
    bus.bram_din  = din_arr_s[mux_idx_s];
    rvalid_d      = rd_grant_s ? gnt_s : '0;
    rdata_d       = rd_grant_s ? bus.bram_dout : rdata_q;
  end

  // Pointer and registered read-return path.
  always_ff @(posedge ck) begin
    if (rst) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed plus randomized bench for bram_arbiter with a behavioural reference model.
// Burst-lock steps are compiled only when BRAM_ARB_BURST_EN is defined.
module tb_bram_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MB = 4;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  bram_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bram_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] init_word(int a);
    return 32'hA5A5_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  // BRAM environment: async read, sync write, known contents after reset.
  logic [DW-1:0] mem [256];
  assign bus.bram_dout = mem[bus.bram_addr];
  always @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.bram_ce && bus.bram_wen) begin
      mem[bus.bram_addr] <= bus.bram_din;
    end
  end

  // Reference model state.
  int            m_ptr = 0;
  logic [DW-1:0] m_mem [256];
  logic [N-1:0]  m_rvalid = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_known = 1'b0;
  bit            m_locked = 1'b0;
  int            m_owner = 0;
  int            m_cnt = 0;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [N-1:0] last_gnt = '0;
  int           last_w = -1;

  function automatic bit bitof(logic [N-1:0] v, int i);
    return 1'(v >> i);
  endfunction

  function automatic logic [AW-1:0] addr_of(int i);
    return AW'(bus.req_addr >> (i*AW));
  endfunction

  function automatic logic [DW-1:0] din_of(int i);
    return DW'(bus.req_din >> (i*DW));
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rq(int i, bit r, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [N-1:0]    m1;
    logic [N*AW-1:0] ma;
    logic [N*DW-1:0] md;
    m1 = N'(1) << i;
    ma = (N*AW)'({AW{1'b1}}) << (i*AW);
    md = (N*DW)'({DW{1'b1}}) << (i*DW);
    bus.req      = r ? (bus.req | m1) : (bus.req & ~m1);
    bus.req_wen  = w ? (bus.req_wen | m1) : (bus.req_wen & ~m1);
    bus.req_addr = (bus.req_addr & ~ma) | ((N*AW)'(a) << (i*AW));
    bus.req_din  = (bus.req_din & ~md) | ((N*DW)'(d) << (i*DW));
  endtask

  task automatic set_lock(int i, bit l);
    logic [N-1:0] m1;
    m1 = N'(1) << i;
    bus.req_lock = l ? (bus.req_lock | m1) : (bus.req_lock & ~m1);
  endtask

  // Who should win this cycle, straight from the round-robin / lock rules.
  function automatic int model_winner();
    int idx;
    if (rst) return -1;
    if (m_locked) return bitof(bus.req, m_owner) ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (bitof(bus.req, idx)) return idx;
    end
    return -1;
  endfunction

  task automatic model_advance(int w);
    logic [AW-1:0] a;
    if (rst) begin
      m_ptr = 0; m_rvalid = '0; m_rdata = '0; m_locked = 1'b0; m_cnt = 0; m_known = 1'b1;
      for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
      return;
    end
    m_rvalid = '0;
    if (w >= 0) begin
      a = addr_of(w);
      if (bitof(bus.req_wen, w)) begin
        m_mem[a] = din_of(w);
      end else begin
        m_rvalid = N'(1) << w;
        m_rdata  = m_mem[a];
      end
    end
    if (m_locked) begin
      if (w >= 0) begin
        m_cnt++;
        if (!bitof(bus.req_lock, m_owner) || m_cnt == MB) begin
          m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
        end
      end else begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
      end
    end else if (w >= 0) begin
      m_ptr = (w + 1) % N;
`ifdef BRAM_ARB_BURST_EN
      if (bitof(bus.req_lock, w) && MB > 1) begin
        m_locked = 1'b1; m_owner = w; m_cnt = 1;
      end
`endif
    end
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then advance.
  task automatic do_cycle(string tag);
    int           w;
    logic [N-1:0] eg;
    #2;
    w  = model_winner();
    eg = (w >= 0) ? (N'(1) << w) : '0;
    chk({tag, "_gnt"}, bus.gnt, eg);
    chk({tag, "_ce"}, bus.bram_ce, (w >= 0));
    chk({tag, "_wen"}, bus.bram_wen, (w >= 0) ? bitof(bus.req_wen, w) : 1'b0);
    if (w >= 0) begin
      chk({tag, "_addr"}, bus.bram_addr, addr_of(w));
      chk({tag, "_din"}, bus.bram_din, din_of(w));
    end
    if (m_known) begin
      chk({tag, "_rvalid"}, bus.rvalid, m_rvalid);
      chk({tag, "_rdata"}, bus.rdata, m_rdata);
    end
    last_gnt = bus.gnt;
    last_w   = w;
    model_advance(w);
    @(posedge ck);
    #1;
  endtask

  initial begin
    bus.req = '0; bus.req_wen = '0; bus.req_addr = '0; bus.req_din = '0; bus.req_lock = '0;
    rst = 1'b1;
    @(posedge ck);
    #1;
    do_cycle("rst0");
    do_cycle("rst1");
    rst = 1'b0;
    chk("reset_rvalid", bus.rvalid, 2'b00);
    chk("reset_rdata", bus.rdata, 32'h0);
    do_cycle("idle");

    // Write then read back through the other requester.
    set_rq(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    do_cycle("t1_wr");
    chk("t1_wr_gnt", last_gnt, 2'b01);
    set_rq(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rq(1, 1'b1, 1'b0, 8'h10, 32'h0);
    do_cycle("t1_rd");
    chk("t1_rvalid", bus.rvalid, 2'b10);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);

    // Two continuous readers alternate.
    set_rq(0, 1'b1, 1'b0, 8'h01, 32'h0);
    set_rq(1, 1'b1, 1'b0, 8'h02, 32'h0);
    for (int k = 0; k < 6; k++) begin
      do_cycle("t2");
      chk("t2_alt", last_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Lone requester 1 granted every cycle.
    set_rq(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rq(1, 1'b1, 1'b0, 8'h03, 32'h0);
    for (int k = 0; k < 3; k++) begin
      do_cycle("t3");
      chk("t3_gnt", last_gnt, 2'b10);
      chk("t3_rvalid", bus.rvalid, 2'b10);
    end

    // Reset right after a read grant.
    set_rq(1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rq(0, 1'b1, 1'b0, 8'h05, 32'h0);
    do_cycle("t4_rd");
    set_rq(1, 1'b1, 1'b0, 8'h06, 32'h0);
    rst = 1'b1;
    do_cycle("t4_rst");
    chk("t4_rst_gnt", last_gnt, 2'b00);
    rst = 1'b0;
    chk("t4_rvalid_cleared", bus.rvalid, 2'b00);
    do_cycle("t4_after");
    chk("t4_first", last_gnt, 2'b01);

    // Withdrawn request never reaches the BRAM.
    set_rq(0, 1'b0, 1'b0, 8'h00, 32'h0);
    do_cycle("t6_pre");
    set_rq(0, 1'b1, 1'b1, 8'h20, 32'h1234_5678);
    set_rq(1, 1'b1, 1'b1, 8'h21, 32'h8765_4321);
    do_cycle("t6_both");
    chk("t6_both_gnt", last_gnt, 2'b01);
    set_rq(1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rq(0, 1'b1, 1'b0, 8'h21, 32'h0);
    do_cycle("t6_drop");
    chk("t6_drop_gnt", last_gnt, 2'b01);
    set_rq(0, 1'b0, 1'b0, 8'h00, 32'h0);
    do_cycle("t6_idle");
    chk("t6_no_write", bus.rdata, init_word(8'h21));

`ifdef BRAM_ARB_BURST_EN
    // Locked burst capped at MB beats.
    set_rq(1, 1'b1, 1'b0, 8'h00, 32'h0);
    do_cycle("t5_pre");
    set_rq(0, 1'b1, 1'b0, 8'h07, 32'h0);
    set_lock(0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      do_cycle("t5");
      chk("t5_seq", last_gnt, (k < 4 || k == 5) ? 2'b01 : 2'b10);
    end
    set_lock(0, 1'b0);
    set_rq(0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rq(1, 1'b0, 1'b0, 8'h00, 32'h0);
    do_cycle("t5_idle");
`endif

    // Random traffic obeying the hold-until-granted protocol.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bitof(bus.req, i) || last_w == i) begin
          set_rq(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), $urandom);
          set_lock(i, 1'($urandom_range(0, 1)));
        end else if ($urandom_range(0, 7) == 0) begin
          set_rq(i, 1'b0, 1'b0, 8'h00, 32'h0);
        end else begin
          set_lock(i, bitof(bus.req_lock, i));
        end
      end
      do_cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Round-robin arbiter that shares one single-port BRAM (async read, sync write, ce/wen strobes) between NUM_REQ requesters. It grants one requester per cycle, muxes that requester's address, data and write strobe onto the BRAM port, and returns registered read data to the winner. It sits between the BRAM instance and client engines such as fetch, DMA and debug.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
DATA_WIDTH, 32, data width of the BRAM word.
ADDR_WIDTH, 8, BRAM address width (depth 256).
MAX_BURST, 4, maximum consecutive locked grants (used only with the optional feature).

Ports:
ck  in  1  clock.
rst  in  1  synchronous active-high reset.
req  in  NUM_REQ  per-requester access request.
req_wen  in  NUM_REQ  per-requester write (1) / read (0).
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
req_din  in  NUM_REQ*DATA_WIDTH  flattened write data.
req_lock  in  NUM_REQ  burst lock request (optional feature only; ignored otherwise).
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the BRAM access.
rdata  out  DATA_WIDTH  registered read data.
rvalid  out  NUM_REQ  one-hot read-data-valid, one cycle after a read grant.
bram_ce  out  1  BRAM chip enable.
bram_wen  out  1  BRAM write enable.
bram_addr  out  ADDR_WIDTH  BRAM address.
bram_din  out  DATA_WIDTH  BRAM write data.
bram_dout  in  DATA_WIDTH  BRAM async read data.

Behaviour:
- Clocking and reset: one clock, ck. Reset is synchronous and active-high on rst.
- Reset values: rvalid=0, rdata=0, pointer ptr=0, state IDLE, burst count=0. While rst is high, gnt=0, bram_ce=0 and bram_wen=0.
- Arbitration (combinational):
  - Search req from index ptr upward, wrapping mod NUM_REQ. The first set bit wins.
  - gnt is one-hot or zero.
  - With no winner: bram_ce=0, bram_wen=0; bram_addr and bram_din hold the winner-0 mux value (don't-care).
- Port mux: with winner w, bram_ce=1, bram_wen=req_wen[w], bram_addr=addr slice w, bram_din=din slice w.
- Write timing: the write commits at the clock edge that ends the grant cycle.
- Read latency: on a read grant in cycle T, bram_dout is captured at the end of T. rdata=that word and rvalid[w]=1 during T+1, for exactly one cycle. A write grant produces rvalid=0. rdata holds its last value when rvalid=0.
- Pointer update: after a grant to w, ptr <= (w+1) mod NUM_REQ. No grant leaves ptr unchanged.
- Requester protocol:
  - Requester holds req, wen, addr and din stable until it sees gnt.
  - It may present a new access, or drop req, on the next cycle.
  - Dropping req before grant is legal (withdrawn request).
- Throughput: one access per cycle. Two always-requesting clients alternate every cycle. A single client is granted every cycle.
- Reset mid-operation: a pending rvalid is cleared. Nothing is granted in the rst cycle. ptr returns to 0.
- FSM (meaningful only with the optional feature):
  - IDLE: normal round-robin.
  - LOCKED(owner, cnt): arbitration is bypassed. Only the owner is granted, if req[owner]=1.

Optional Feature:
Macro BRAM_ARB_BURST_EN.
- Defined:
  - A grant to w with req_lock[w]=1 enters LOCKED, owner=w, cnt=1.
  - Each further owner grant increments cnt.
  - Exit to IDLE occurs when req_lock[owner]=0, when req[owner]=0, or after a grant with cnt==MAX_BURST. Exit sets ptr=owner+1.
  - Other requesters wait while LOCKED.
  - A cycle in LOCKED with req[owner]=0 grants nobody and exits.
- Undefined: req_lock is ignored, the FSM is absent, and every grant follows round-robin.

Decomposition:
- Package bram_arb_pkg holds:
  - the arb_state_t enum (IDLE, LOCKED);
  - the pointer-increment-with-wrap function;
  - the MAX_NUM_REQ=4 constant.
- Sub-module rr_picker is natural: a combinational find-first-set starting from ptr, outputting a one-hot vector and the winner index.

Test Plan:
1. Reset, then requester 0 writes 0xDEADBEEF to address 0x10 -> gnt=01, bram_ce=1, bram_wen=1 that cycle. A later requester-1 read of 0x10 -> rvalid=10 with rdata=0xDEADBEEF one cycle after its gnt.
2. Both requesters read continuously (addr 0x01 / 0x02) -> gnt alternates 01,10,01,10. rvalid alternates with a one-cycle lag and the matching data.
3. Only requester 1 requests for 3 cycles -> gnt=10 every cycle, ptr wraps to 0 each time, 3 rvalid pulses.
4. rst asserted the cycle after a read grant -> rvalid=0 next cycle. After release, with both requesting, requester 0 wins first (ptr=0).
5. With BRAM_ARB_BURST_EN and MAX_BURST=4, requester 0 locks and requests 6 beats while requester 1 requests -> gnt=01 for 4 cycles, then 10, then 01.
6. Requester 1 raises req then drops it before a grant while requester 0 holds the grant -> no gnt[1] and no BRAM access for requester 1.
